// File: rtl/rvx_core_trap_sequencer.sv
// Trap sequencer for the RVX core: accepts exceptions/interrupts, sequences mret and wfi,
// and drives fetch redirect and stage-1 flush. Define RVX_WFI_EN to enable the WAIT_FOR_INTERRUPT state.
module rvx_core_trap_sequencer (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        clock_enable,
  input  logic        ecall_s1,
  input  logic        ebreak_s1,
  input  logic        mret_s1,
  input  logic        wfi_s1,
  input  logic        illegal_instruction_s1,
  input  logic        misaligned_instruction_address_s1,
  input  logic        misaligned_load_s1,
  input  logic        misaligned_store_s1,
  input  logic        interrupt_pending_s1,
  input  logic        global_interrupt_enable_s1,
  input  logic [31:0] trap_handler_address_s1,
  input  logic [31:0] exception_address_s1,
  output logic [3:0]  current_state_s1,
  output logic        take_trap_s1,
  output logic        pc_redirect_s1,
  output logic [31:0] pc_redirect_address_s1,
  output logic        flush_s1
);

  typedef enum logic [3:0] {
    ST_RESET              = 4'd0,
    ST_OPERATING          = 4'd1,
    ST_TRAP_TAKEN         = 4'd2,
    ST_TRAP_RETURN        = 4'd3,
    ST_WAIT_FOR_INTERRUPT = 4'd4
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic        w_exception;
  logic        w_interrupt_taken;
  logic        w_wfi_request;
  logic        w_take_trap;
  logic        w_pc_redirect;
  logic [31:0] w_pc_redirect_address;
  logic        w_flush;

  assign w_exception = illegal_instruction_s1 | ecall_s1 | ebreak_s1 |
                       misaligned_instruction_address_s1 | misaligned_load_s1 |
                       misaligned_store_s1;
  assign w_interrupt_taken = interrupt_pending_s1 & global_interrupt_enable_s1;

`ifdef RVX_WFI_EN
  assign w_wfi_request = wfi_s1;
`else
  // wfi is a plain NOP in this build.
  logic w_unused_wfi;
  assign w_unused_wfi  = wfi_s1;
  assign w_wfi_request = 1'b0;
`endif

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    w_next_state          = ST_RESET;
    w_take_trap           = 1'b0;
    w_pc_redirect         = 1'b0;
    w_pc_redirect_address = 32'h0;
    w_flush               = 1'b1;
    case (r_state)
      ST_RESET: w_next_state = ST_OPERATING;
      ST_OPERATING: begin
        w_take_trap = w_exception | w_interrupt_taken;
        w_flush     = w_take_trap | mret_s1;
        if (w_take_trap)        w_next_state = ST_TRAP_TAKEN;
        else if (mret_s1)       w_next_state = ST_TRAP_RETURN;
        else if (w_wfi_request) w_next_state = ST_WAIT_FOR_INTERRUPT;
        else                    w_next_state = ST_OPERATING;
      end
      ST_TRAP_TAKEN: begin
        w_pc_redirect         = 1'b1;
        w_pc_redirect_address = trap_handler_address_s1;
        w_next_state          = ST_OPERATING;
      end
      ST_TRAP_RETURN: begin
        w_pc_redirect         = 1'b1;
        w_pc_redirect_address = exception_address_s1;
        w_next_state          = ST_OPERATING;
      end
`ifdef RVX_WFI_EN
      // Wake on any pending interrupt, even with MIE clear.
      ST_WAIT_FOR_INTERRUPT:
        w_next_state = interrupt_pending_s1 ? ST_OPERATING : ST_WAIT_FOR_INTERRUPT;
`endif
      default: w_next_state = ST_RESET;
    endcase
  end

  // NOTE: state registers use non-blocking assignment so all flops update together at the edge.
  always_ff @(posedge clock) begin
    if (!reset_n)          r_state <= ST_RESET;
    else if (clock_enable) r_state <= w_next_state;
  end

  assign current_state_s1       = r_state;
  assign take_trap_s1           = w_take_trap;
  assign pc_redirect_s1         = w_pc_redirect;
  assign pc_redirect_address_s1 = w_pc_redirect_address;
  assign flush_s1               = w_flush;

endmodule
